// File: rtl/encoder_round_scheduler.sv
// Round/step sequencer for the matrix encoder: loads the shared state register,
// then walks every step unit of every round through a start/done handshake.
module encoder_round_scheduler #(
  parameter int NUM_STEPS  = 5,
  parameter int NUM_ROUNDS = 24,
  parameter int ROUND_W    = 5,
  parameter int STEP_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_STEPS-1:0] step_done,
  output logic [NUM_STEPS-1:0] step_start,
  output logic [STEP_W-1:0]    step_sel,
  output logic                 load_in,
  output logic                 state_we,
  output logic [ROUND_W-1:0]   round_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(NUM_STEPS - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_FIN
  } state_t;

  state_t               state, state_nxt;
  logic [STEP_W-1:0]    step_cnt, step_cnt_nxt;
  logic [ROUND_W-1:0]   round_nxt;
  logic                 err_nxt;
  logic [NUM_STEPS-1:0] active_mask;
  logic                 hit;
  logic                 stray;

  assign active_mask = NUM_STEPS'(1) << step_cnt;
  assign hit         = |(step_done & active_mask);
  assign stray       = |(step_done & ~active_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      step_cnt  <= '0;
      round_idx <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_cnt  <= step_cnt_nxt;
      round_idx <= round_nxt;
      err       <= err_nxt;
    end
  end

  // Counters are cleared on entry to LOAD so they already read zero during LOAD.
  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    round_nxt    = round_idx;
    err_nxt      = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_LOAD;
          step_cnt_nxt = '0;
          round_nxt    = '0;
          err_nxt      = 1'b0;
        end
      end
      S_LOAD: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (stray) err_nxt = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (stray) err_nxt = 1'b1;
        if (hit) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (step_cnt < LAST_STEP) begin
          step_cnt_nxt = step_cnt + STEP_W'(1);
          state_nxt    = S_ISSUE;
        end else if (round_idx < LAST_ROUND) begin
          step_cnt_nxt = '0;
          round_nxt    = round_idx + ROUND_W'(1);
          state_nxt    = S_ISSUE;
        end else begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        step_cnt_nxt = '0;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // All outputs are decoded from registered state only.
  assign step_start = (state == S_ISSUE) ? active_mask : '0;
  assign step_sel   = step_cnt;
  assign load_in    = (state == S_LOAD);
  assign state_we   = (state == S_LOAD) || (state == S_WRITE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);

endmodule

// File: tb/tb_encoder_round_scheduler.sv
// Bench for encoder_round_scheduler: a 2-round instance driven by latency tables,
// random latencies and corner sequences, plus a 24-round instance for round_idx.
module tb_encoder_round_scheduler;

  localparam int S  = 5;
  localparam int RA = 2;
  localparam int RB = 24;
  localparam int RW = 5;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: two rounds
  logic          start_a;
  logic [S-1:0]  step_done_a, step_start_a;
  logic [S-1:0]  resp_a = '0;
  logic [S-1:0]  spur_a;
  logic [SW-1:0] step_sel_a;
  logic          load_in_a, state_we_a, busy_a, done_a, err_a;
  logic [RW-1:0] round_idx_a;
  assign step_done_a = resp_a | spur_a;

  encoder_round_scheduler #(.NUM_STEPS(S), .NUM_ROUNDS(RA), .ROUND_W(RW), .STEP_W(SW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .step_done(step_done_a),
    .step_start(step_start_a), .step_sel(step_sel_a), .load_in(load_in_a),
    .state_we(state_we_a), .round_idx(round_idx_a), .busy(busy_a), .done(done_a), .err(err_a));

  // instance B: 24 rounds, every step answers after one cycle
  logic          start_b;
  logic [S-1:0]  step_start_b;
  logic [S-1:0]  resp_b = '0;
  logic [S-1:0]  prev_b = '0;
  logic [SW-1:0] step_sel_b;
  logic          load_in_b, state_we_b, busy_b, done_b, err_b;
  logic [RW-1:0] round_idx_b;

  encoder_round_scheduler #(.NUM_STEPS(S), .NUM_ROUNDS(RB), .ROUND_W(RW), .STEP_W(SW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .step_done(resp_b),
    .step_start(step_start_b), .step_sel(step_sel_b), .load_in(load_in_b),
    .state_we(state_we_b), .round_idx(round_idx_b), .busy(busy_b), .done(done_b), .err(err_b));

  int checks = 0;
  int errors = 0;

  // step-unit model for A: answers each start after a table or random latency
  int lat_tab [S];
  bit rand_lat = 1'b0;
  int lat_q [$];
  int pend_a = 0, cnt_a = 0, pk_a = 0;

  always @(negedge clk) begin
    resp_a = '0;
    if (!rst) begin
      pend_a = 0;
    end else begin
      if (pend_a != 0) begin
        cnt_a = cnt_a - 1;
        if (cnt_a == 0) begin
          resp_a[pk_a] = 1'b1;
          pend_a = 0;
        end
      end
      if (step_start_a != '0) begin
        for (int j = 0; j < S; j++) if (step_start_a[j]) pk_a = j;
        cnt_a = rand_lat ? int'($urandom_range(6, 1)) : lat_tab[pk_a];
        lat_q.push_back(cnt_a);
        pend_a = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      resp_b = '0;
      prev_b = '0;
    end else begin
      resp_b = prev_b;
      prev_b = step_start_b;
    end
  end

  // event recorders
  int load_q[$], load_err_q[$], iss_c[$], iss_k[$], iss_r[$];
  int wr_c[$], wr_sel[$], wr_r[$], done_q[$], done_err_q[$];
  int wr_sel_b[$], wr_r_b[$], done_b_q[$], done_r_b[$];
  int maxr_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (load_in_a && state_we_a) begin
        load_q.push_back(cyc);
        load_err_q.push_back(int'(err_a));
      end
      if (step_start_a != '0) begin
        int kk;
        kk = -1;
        if ($onehot(step_start_a))
          for (int j = 0; j < S; j++) if (step_start_a[j]) kk = j;
        iss_c.push_back(cyc);
        iss_k.push_back(kk);
        iss_r.push_back(int'(round_idx_a));
      end
      if (state_we_a && !load_in_a) begin
        wr_c.push_back(cyc);
        wr_sel.push_back(int'(step_sel_a));
        wr_r.push_back(int'(round_idx_a));
      end
      if (done_a) begin
        done_q.push_back(cyc);
        done_err_q.push_back(int'(err_a));
      end
      if (state_we_b && !load_in_b) begin
        wr_sel_b.push_back(int'(step_sel_b));
        wr_r_b.push_back(int'(round_idx_b));
      end
      if (busy_b && int'(round_idx_b) > maxr_b) maxr_b = int'(round_idx_b);
      if (done_b) begin
        done_b_q.push_back(cyc);
        done_r_b.push_back(int'(round_idx_b));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int t0 = 0;

  task automatic start_enc(input bit hold);
    load_q.delete(); load_err_q.delete(); iss_c.delete(); iss_k.delete(); iss_r.delete();
    wr_c.delete(); wr_sel.delete(); wr_r.delete(); done_q.delete(); done_err_q.delete();
    lat_q.delete();
    t0 = cyc;
    start_a = 1'b1;
    tick();
    if (!hold) start_a = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_q.size() == 0) chk("done_timeout", 0, 1);
  endtask

  // Reference timeline: LOAD at t0+1, first issue at t0+2, each step costs L+2,
  // the write lands L+1 after its issue, steps 0..S-1 repeated per round.
  task automatic check_model(input string tag, input int exp_err);
    int t, n, e0;
    if (done_q.size() == 0) return;
    chk({tag, "_loads"}, load_q.size(), 1);
    if (load_q.size() > 0) begin
      chk({tag, "_load_cyc"}, load_q[0] - t0, 1);
      chk({tag, "_load_err"}, load_err_q[0], 0);
    end
    n = RA * S;
    chk({tag, "_issues"}, iss_c.size(), n);
    chk({tag, "_writes"}, wr_c.size(), n);
    t  = t0 + 2;
    e0 = errors;
    for (int i = 0; i < n; i++) begin
      if (i >= iss_c.size() || i >= wr_c.size() || i >= lat_q.size() || errors != e0) break;
      chk({tag, "_iss_cyc"}, iss_c[i], t);
      chk({tag, "_iss_k"}, iss_k[i], i % S);
      chk({tag, "_iss_round"}, iss_r[i], i / S);
      chk({tag, "_wr_cyc"}, wr_c[i], t + lat_q[i] + 1);
      chk({tag, "_wr_sel"}, wr_sel[i], i % S);
      chk({tag, "_wr_round"}, wr_r[i], i / S);
      t = t + lat_q[i] + 2;
    end
    chk({tag, "_done_cyc"}, done_q[0], t);
    chk({tag, "_done_err"}, done_err_q[0], exp_err);
  endtask

  typedef struct {
    bit [S-1:0][3:0] lat;
    int              exp_done;
  } vec_t;
  vec_t tab [3];

  initial begin
    tab[0].lat = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1}; tab[0].exp_done = 32;
    tab[1].lat = {4'd2, 4'd5, 4'd1, 4'd3, 4'd1}; tab[1].exp_done = 46;
    tab[2].lat = {4'd6, 4'd1, 4'd2, 4'd1, 4'd4}; tab[2].exp_done = 50;
    for (int k = 0; k < S; k++) lat_tab[k] = 1;

    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; spur_a = '0;
    tick(); tick(); tick();
    chk("rst_step_start", int'(step_start_a), 0);
    chk("rst_step_sel", int'(step_sel_a), 0);
    chk("rst_load_in", int'(load_in_a), 0);
    chk("rst_state_we", int'(state_we_a), 0);
    chk("rst_round_idx", int'(round_idx_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_err", int'(err_a), 0);
    rst = 1'b1;
    tick(); tick();

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < S; k++) lat_tab[k] = int'(tab[i].lat[k]);
      rand_lat = 1'b0;
      start_enc(1'b0);
      wait_done(400);
      if (done_q.size() > 0) begin
        chk("tab_done_cyc", done_q[0] - t0, tab[i].exp_done);
        chk("tab_we_pulses", load_q.size() + wr_c.size(), 1 + RA * S);
        check_model("tab", 0);
        chk("tab_busy_at_done", int'(busy_a), 1);
        tick();
        chk("tab_busy_after", int'(busy_a), 0);
        chk("tab_done_pulse", int'(done_a), 0);
        chk("tab_idle_sel", int'(step_sel_a), 0);
      end
      tick();
    end

    // stray completion on step 3 while step 1 is pending
    lat_tab = '{1, 5, 1, 1, 1};
    start_enc(1'b0);
    for (int n = 0; n < 100 && iss_k.size() < 2; n++) tick();
    chk("spur_reach_step1", (iss_k.size() >= 2) ? iss_k[1] : -1, 1);
    tick();
    chk("spur_err_before", int'(err_a), 0);
    spur_a = 5'b01000;
    tick();
    spur_a = '0;
    chk("spur_err_rise", int'(err_a), 1);
    wait_done(400);
    check_model("spur", 1);
    tick();
    chk("spur_err_sticky", int'(err_a), 1);
    tick();

    // start held high through a whole encode
    lat_tab = '{1, 1, 1, 1, 1};
    start_enc(1'b1);
    wait_done(400);
    check_model("hold", 0);
    for (int n = 0; n < 10 && load_q.size() < 2; n++) tick();
    if (load_q.size() >= 2 && done_q.size() >= 1) chk("hold_reload_gap", load_q[1] - done_q[0], 2);
    else chk("hold_reload_seen", load_q.size(), 2);
    chk("hold_one_done", done_q.size(), 1);
    start_a = 1'b0;
    for (int n = 0; n < 100 && done_q.size() < 2; n++) tick();
    if (done_q.size() >= 2 && load_q.size() >= 2) chk("hold_second_len", done_q[1] - load_q[1], 31);
    else chk("hold_second_done", done_q.size(), 2);
    tick();

    // random latencies against the timeline model
    for (int i = 0; i < 6; i++) begin
      rand_lat = 1'b1;
      repeat ($urandom_range(3, 0)) tick();
      start_enc(1'b0);
      wait_done(400);
      check_model("rnd", 0);
      tick();
    end
    rand_lat = 1'b0;

    // 24-round instance: round_idx progression
    start_b = 1'b1;
    t0 = cyc;
    tick();
    start_b = 1'b0;
    for (int n = 0; n < 500 && done_b_q.size() == 0; n++) tick();
    if (done_b_q.size() == 0) chk("b_done_timeout", 0, 1);
    else begin
      int e0;
      chk("b_done_cyc", done_b_q[0] - t0, 2 + RB * S * 3);
      chk("b_round_at_fin", done_r_b[0], RB - 1);
      chk("b_max_round", maxr_b, RB - 1);
      chk("b_err", int'(err_b), 0);
      chk("b_writes", wr_sel_b.size(), RB * S);
      e0 = errors;
      for (int i = 0; i < wr_sel_b.size() && errors == e0; i++) begin
        chk("b_wr_sel", wr_sel_b[i], i % S);
        chk("b_wr_round", wr_r_b[i], i / S);
      end
      tick();
      chk("b_busy_after", int'(busy_b), 0);
      chk("b_round_hold", int'(round_idx_b), RB - 1);
    end
    tick();

    // async reset during WAIT of round 1, step 2
    lat_tab = '{1, 1, 6, 1, 1};
    start_enc(1'b0);
    for (int n = 0; n < 200 && !(iss_k.size() > 0 && iss_k[$] == 2 && iss_r[$] == 1); n++) tick();
    chk("ar_reach", (iss_k.size() > 0 && iss_k[$] == 2 && iss_r[$] == 1) ? 1 : 0, 1);
    tick();
    #1 rst = 1'b0;
    #1;
    chk("ar_step_start", int'(step_start_a), 0);
    chk("ar_step_sel", int'(step_sel_a), 0);
    chk("ar_load_in", int'(load_in_a), 0);
    chk("ar_state_we", int'(state_we_a), 0);
    chk("ar_round_idx", int'(round_idx_a), 0);
    chk("ar_busy", int'(busy_a), 0);
    chk("ar_done", int'(done_a), 0);
    chk("ar_err", int'(err_a), 0);
    tick(); tick();
    rst = 1'b1;
    repeat (30) tick();
    chk("ar_no_done", done_q.size(), 0);
    chk("ar_idle", int'(busy_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_round_scheduler.md
# encoder_round_scheduler

Sequences the matrix-encoder step units (column parity, rotate, permute, revaluate, round-constant add) over a fixed number of rounds on the shared `NUM_CELLS`-bit state register. It loads the external state, then starts each step unit in order with a start/done handshake. After each step it writes that step's result back into the state register. It raises `done` after the last round. The block has no datapath of its own: it drives step starts, the state-register mux select and write enable, and the round index consumed by the round-constant step.

## Interface
Parameters:
- `NUM_STEPS`, 5, number of step units per round, served in index order 0..NUM_STEPS-1
- `NUM_ROUNDS`, 24, rounds per encode; legal range 1..2^ROUND_W
- `ROUND_W`, 5, width of `round_idx`
- `STEP_W`, 3, width of `step_sel`; must satisfy 2^STEP_W ≥ NUM_STEPS

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `start` in 1 — request an encode; sampled only in IDLE
- `step_done` in NUM_STEPS — per-step completion from the step units
- `step_start` out NUM_STEPS — one-hot, one-cycle start pulse to the active step
- `step_sel` out STEP_W — state-register input mux select; selects the active step's output
- `load_in` out 1 — selects the external `data_in` into the state register
- `state_we` out 1 — state-register write enable
- `round_idx` out ROUND_W — current round, 0..NUM_ROUNDS-1
- `busy` out 1 — high in every state except IDLE
- `done` out 1 — one-cycle completion pulse
- `err` out 1 — sticky protocol-error flag

## Operation
- States are IDLE, LOAD, ISSUE, WAIT, WRITE and FIN. All outputs are registered or decoded from registered state only.
- IDLE:
  - `start`=1 → LOAD.
  - `start` is ignored in every other state; the block does not queue it.
- LOAD:
  - Drives `load_in`=1 and `state_we`=1.
  - Clears the step counter, `round_idx` and `err`.
  - → ISSUE.
- ISSUE:
  - Drives `step_start[k]`=1 for exactly this cycle, where k is the step counter.
  - → WAIT.
- WAIT:
  - Holds until `step_done[k]`=1.
  - Any `step_done[j]` with j≠k, in WAIT or ISSUE, sets `err`. Operation continues regardless.
  - `step_done[k]` seen in the ISSUE cycle is not accepted. Step units must respond no earlier than the cycle after `step_start`.
  - On `step_done[k]` → WRITE.
- WRITE:
  - Drives `state_we`=1 and `load_in`=0; `step_sel`=k.
  - If k<NUM_STEPS-1: k+1, → ISSUE.
  - Otherwise, if `round_idx`<NUM_ROUNDS-1: k=0, `round_idx`+1, → ISSUE.
  - Otherwise → FIN.
- FIN:
  - `done`=1 for one cycle.
  - `round_idx` holds NUM_ROUNDS-1 until the next LOAD.
  - → IDLE.
- Counters never wrap during an encode: the step counter stops at NUM_STEPS-1 and `round_idx` stops at NUM_ROUNDS-1.
- `step_sel` equals the step counter in all states. It is 0 in IDLE and LOAD.
- `err` is cleared only by reset or LOAD and stays visible after FIN.
- There is no timeout. A step that never responds holds the block in WAIT until reset.

## Timing
- Reset values: state IDLE; `step_start`=0, `step_sel`=0, `load_in`=0, `state_we`=0, `round_idx`=0, `busy`=0, `done`=0, `err`=0.
- Reset asserted mid-encode returns the block to IDLE asynchronously. No `done` is produced and any pending step result is discarded.
- Cycle timeline, with `start` sampled at cycle 0:
  - LOAD at cycle 1.
  - First `step_start` at cycle 2.
  - If a step responds L≥1 cycles after its start (ISSUE at cycle c, `step_done` at c+L), WRITE is at c+L+1 and the next ISSUE at c+L+2. Each step therefore costs L+2 cycles.
- `done` is asserted at cycle 2 + Σ over all rounds and steps of (L+2).
- `busy` rises at cycle 1 and falls in the cycle after `done`.
- A new `start` is accepted in the cycle after FIN at the earliest.

## Test plan
- Reset, then NUM_ROUNDS=2, NUM_STEPS=5, every step responding with L=1, `start` at cycle 0:
  - `step_start` visits 0..4 twice.
  - `state_we` pulses 11 times: one LOAD plus 10 WRITEs.
  - `done` at cycle 32; `err`=0.
- Variable latency, NUM_ROUNDS=1, L={1,3,1,5,2}:
  - `done` at cycle 2+(3+5+3+7+4)=24.
  - `step_sel` in each WRITE equals the active step.
- Spurious completion: assert `step_done[3]` while waiting on step 1:
  - `err` rises the next cycle and stays high through `done`.
  - The next `start` clears it in LOAD.
- `start` held high throughout an encode: exactly one `done`, then a new LOAD in the cycle after returning to IDLE.
- Async reset during WAIT of round 1, step 2: all outputs return to reset values immediately and no `done` pulse is produced.
- Check `round_idx` with NUM_ROUNDS=24:
  - Increments only on the last-step WRITE.
  - Reads 23 during the final round and at FIN, and never reaches 24.
